mem_stage: RTL and testbench

//  MIPS pipeline MEM stage. Consumes the EX/MEM register outputs of the EX stage.
//  - Performs data-memory loads and stores in byte, halfword and word sizes.
//  - Resolves branches and drives pc_src and branch_target back to IF.
//  - Registers write-back data into a MEM/WB pipeline register for the WB stage.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/mem_stage_if.sv | 46 ++++
 rtl/mem_wb_reg.sv | 26 ++
 rtl/mem_stage.sv | 79 +++++++
 tb/tb_mem_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: load/store size codes, bus widths, MEM/WB record.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Access size/sign code carried with every load/store.
  typedef enum logic [1:0] {
    LM_WORD  = 2'b00,
    LM_HALF  = 2'b01,
    LM_BYTE  = 2'b10,
    LM_UBYTE = 2'b11
  } load_mode_e;

  // The five fields handed from MEM to WB.
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  wb_dest;
  } memwb_t;

  // Byte lanes touched by a store of the given size at the given byte offset.
  // Halfword uses only lo[1]; word ignores the offset entirely.
  function automatic logic [3:0] lane_enable(input logic [1:0] mode, input logic [1:0] lo);
    logic [3:0] be;
    case (mode)
      LM_WORD: be = 4'b1111;
      LM_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b0001 << lo;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the byte enables alone select what lands.
  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] mode, input logic [DATA_W-1:0] rt);
    logic [DATA_W-1:0] d;
    case (mode)
      LM_WORD: d = rt;
      LM_HALF: d = {2{rt[15:0]}};
      default: d = {4{rt[7:0]}};
    endcase
    return d;
  endfunction

  // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [1:0] mode, input logic [1:0] lo,
                                                    input logic [DATA_W-1:0] word);
    logic [15:0]       h;
    logic [7:0]        b;
    logic [DATA_W-1:0] r;
    h = lo[1] ? word[31:16] : word[15:0];
    b = word[{lo, 3'b000} +: 8];
    case (mode)
      LM_WORD: r = word;
      LM_HALF: r = {{16{h[15]}}, h};
      LM_BYTE: r = {{24{b[7]}}, b};
      default: r = {24'h0, b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, branch redirect and MEM/WB outputs of the MEM stage as one bundle.
// Latency: n/a (wires only).
// Backpressure: none; the pipeline advances every cycle.
// Modports: master = EX/WB side (drives in_*, observes results), slave = mem_stage.
interface mem_stage_if;
  import mips_pkg::*;

  // EX/MEM register outputs
  logic              in_RegWrite;
  logic              in_MemWrite;
  logic              in_MemRead;
  logic              in_MemToReg;
  logic [1:0]        in_load_mode;
  logic              in_branch;
  logic              in_zero;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_aluResult;
  logic [DATA_W-1:0] in_rt;
  logic [REG_W-1:0]  in_writebackDest;

  // Branch redirect to IF (combinational)
  logic              pc_src;
  logic [DATA_W-1:0] branch_target;

  // MEM/WB register outputs
  logic              RegWrite_out;
  logic              MemToReg_out;
  logic [DATA_W-1:0] readData_out;
  logic [DATA_W-1:0] aluResult_out;
  logic [REG_W-1:0]  writebackDest_out;

  modport master (
    output in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_load_mode,
           in_branch, in_zero, in_pc, in_aluResult, in_rt, in_writebackDest,
    input  pc_src, branch_target,
           RegWrite_out, MemToReg_out, readData_out, aluResult_out, writebackDest_out
  );

  modport slave (
    input  in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_load_mode,
           in_branch, in_zero, in_pc, in_aluResult, in_rt, in_writebackDest,
    output pc_src, branch_target,
           RegWrite_out, MemToReg_out, readData_out, aluResult_out, writebackDest_out
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank; async active-low reset clears every field.
// Latency: 1 cycle, loads on every rising edge.
// Backpressure: none (no stall or flush).
// Ports: clk, rst_n; i_d = next MEM/WB record; o_q = registered record.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  memwb_t i_d,
  output memwb_t o_q
);

  memwb_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte/half/word data memory, branch resolve, MEM/WB register.
// Latency: loads and all MEM/WB fields 1 cycle; pc_src/branch_target combinational.
// Backpressure: none; accepts one instruction per cycle.
// Ports: clk, rst_n (async active-low); bus = mem_stage_if.slave (EX/MEM in, redirect + MEM/WB out).
module mem_stage
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);

  // Data memory; deliberately not reset.
  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lo;
  logic              w_we;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rword;
  logic [DATA_W-1:0] w_load;
  memwb_t            w_memwb_d;
  memwb_t            w_memwb_q;

  // Address bits above the word index alias onto the same words.
  assign w_idx = bus.in_aluResult[ADDR_W+1:2];
  assign w_lo  = bus.in_aluResult[1:0];

  // A store whose edge lands while reset is held is dropped.
  assign w_we    = bus.in_MemWrite & rst_n;
  assign w_be    = lane_enable(bus.in_load_mode, w_lo);
  assign w_wdata = store_data(bus.in_load_mode, bus.in_rt);

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Asynchronous read sees the array before this edge's write, so a combined
  // read+write returns the old word while the new one still lands.
  assign w_rword = r_mem[w_idx];
  assign w_load  = bus.in_MemRead ? load_extend(bus.in_load_mode, w_lo, w_rword) : '0;

  // Branch redirect stays unregistered so IF can act in the same cycle.
  assign bus.pc_src        = bus.in_branch & bus.in_zero;
  assign bus.branch_target = bus.in_pc;

  always_comb begin
    w_memwb_d            = '0;
    w_memwb_d.reg_write  = bus.in_RegWrite;
    w_memwb_d.mem_to_reg = bus.in_MemToReg;
    w_memwb_d.read_data  = w_load;
    w_memwb_d.alu_result = bus.in_aluResult;
    w_memwb_d.wb_dest    = bus.in_writebackDest;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_memwb_d),
    .o_q   (w_memwb_q)
  );

  assign bus.RegWrite_out      = w_memwb_q.reg_write;
  assign bus.MemToReg_out      = w_memwb_q.mem_to_reg;
  assign bus.readData_out      = w_memwb_q.read_data;
  assign bus.aluResult_out     = w_memwb_q.alu_result;
  assign bus.writebackDest_out = w_memwb_q.wb_dest;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, stores/loads of every size, branch, pass-through.
// Latency: checks MEM/WB outputs 1 ns after the capturing edge.
// Backpressure: n/a.
module tb_mem_stage;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mem_stage_if bus ();

  mem_stage #(.MEM_WORDS(256), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rw, input logic mw, input logic mr, input logic m2r,
                        input logic [1:0] mode, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [4:0] dest);
    bus.in_RegWrite      = rw;
    bus.in_MemWrite      = mw;
    bus.in_MemRead       = mr;
    bus.in_MemToReg      = m2r;
    bus.in_load_mode     = mode;
    bus.in_aluResult     = addr;
    bus.in_rt            = rt;
    bus.in_writebackDest = dest;
  endtask

  // Advance through one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.in_branch = 1'b0;
    bus.in_zero   = 1'b0;
    bus.in_pc     = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, LM_WORD, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_alu",  bus.aluResult_out, 32'h0);
    chk("reset_rw",   {31'h0, bus.RegWrite_out}, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Seed word 0x30 so a store dropped during reset can be detected later.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, LM_WORD, 32'h30, 32'h1111_1111, 5'd0);
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, LM_WORD, 32'hABC, 32'h0, 5'd9);
    step();
    chk("pre_rst_alu", bus.aluResult_out, 32'hABC);
    chk("pre_rst_dst", {27'h0, bus.writebackDest_out}, 32'd9);

    // Reset mid-cycle with a store and nonzero controls on the inputs.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, LM_WORD, 32'h30, 32'h2222_2222, 5'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_now_alu", bus.aluResult_out, 32'h0);
    chk("rst_now_dst", {27'h0, bus.writebackDest_out}, 32'h0);
    chk("rst_now_rw",  {31'h0, bus.RegWrite_out}, 32'h0);
    chk("rst_now_m2r", {31'h0, bus.MemToReg_out}, 32'h0);
    chk("rst_now_rd",  bus.readData_out, 32'h0);
    step();
    chk("rst_hold_alu", bus.aluResult_out, 32'h0);
    chk("rst_hold_rw",  {31'h0, bus.RegWrite_out}, 32'h0);
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, LM_WORD, 32'h30, 32'h0, 5'd0);
    step();
    chk("rst_store_dropped", bus.readData_out, 32'h1111_1111);

    // Word store then load.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, LM_WORD, 32'h10, 32'hDEAD_BEEF, 5'd0);
    step();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_WORD, 32'h10, 32'h0, 5'd4);
    step();
    chk("word_load", bus.readData_out, 32'hDEAD_BEEF);
    chk("word_m2r",  {31'h0, bus.MemToReg_out}, 32'h1);

    // Byte store into lane 1; upper rt bits must not land.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, LM_BYTE, 32'h11, 32'h1234_5680, 5'd0);
    step();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_WORD, 32'h10, 32'h0, 5'd4);
    step();
    chk("byte_word_view", bus.readData_out, 32'hDEAD_80EF);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_BYTE, 32'h11, 32'h0, 5'd4);
    step();
    chk("byte_signed", bus.readData_out, 32'hFFFF_FF80);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_UBYTE, 32'h11, 32'h0, 5'd4);
    step();
    chk("byte_unsigned", bus.readData_out, 32'h0000_0080);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_UBYTE, 32'h13, 32'h0, 5'd4);
    step();
    chk("byte_lane3", bus.readData_out, 32'h0000_00DE);
    // Address bits above the word index are ignored: 0x410 aliases 0x10.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_WORD, 32'h410, 32'h0, 5'd4);
    step();
    chk("alias_load", bus.readData_out, 32'hDEAD_80EF);

    // Halfword store into the upper half of word 0x20.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, LM_WORD, 32'h20, 32'h5566_7788, 5'd0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, LM_HALF, 32'h22, 32'h1234_ABCD, 5'd0);
    step();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_HALF, 32'h22, 32'h0, 5'd5);
    step();
    chk("half_signed", bus.readData_out, 32'hFFFF_ABCD);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_WORD, 32'h20, 32'h0, 5'd5);
    step();
    chk("half_word_view", bus.readData_out, 32'hABCD_7788);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_HALF, 32'h21, 32'h0, 5'd5);
    step();
    chk("half_low_pos", bus.readData_out, 32'h0000_7788);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_HALF, 32'h23, 32'h0, 5'd5);
    step();
    chk("half_a0_ignored", bus.readData_out, 32'hFFFF_ABCD);

    // Read and write together: old data returned, new data stored.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, LM_WORD, 32'h10, 32'h0BAD_F00D, 5'd6);
    step();
    chk("rw_old_data", bus.readData_out, 32'hDEAD_80EF);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, LM_WORD, 32'h10, 32'h0, 5'd6);
    step();
    chk("rw_new_data", bus.readData_out, 32'h0BAD_F00D);

    // Branch resolve is combinational.
    bus.in_branch = 1'b1;
    bus.in_zero   = 1'b1;
    bus.in_pc     = 32'h40;
    #1;
    chk("br_taken",  {31'h0, bus.pc_src}, 32'h1);
    chk("br_target", bus.branch_target, 32'h40);
    bus.in_zero = 1'b0;
    #1;
    chk("br_nz", {31'h0, bus.pc_src}, 32'h0);
    bus.in_branch = 1'b0;
    bus.in_zero   = 1'b1;
    #1;
    chk("br_nobranch", {31'h0, bus.pc_src}, 32'h0);
    bus.in_zero = 1'b0;

    // Pass-through with no load; previous readData_out is nonzero.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, LM_WORD, 32'h55, 32'hFFFF, 5'd7);
    step();
    chk("pt_alu", bus.aluResult_out, 32'h55);
    chk("pt_dst", {27'h0, bus.writebackDest_out}, 32'd7);
    chk("pt_rw",  {31'h0, bus.RegWrite_out}, 32'h1);
    chk("pt_rd",  bus.readData_out, 32'h0);
    chk("pt_m2r", {31'h0, bus.MemToReg_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
